// File: rtl/photon_seq_pkg.sv
// Shared types and record layout for the photon bin sequencer.
// The record is {bin_idx[15:0], run_id[7:0], flags[7:0], count[31:0]}.
package photon_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        COUNT
    } seq_state_t;

    localparam int REC_W       = 64;
    localparam int COUNT_LSB   = 0;
    localparam int COUNT_W     = 32;
    localparam int FLAGS_LSB   = 32;
    localparam int FLAGS_W     = 8;
    localparam int RUN_ID_LSB  = 40;
    localparam int RUN_ID_W    = 8;
    localparam int BIN_IDX_LSB = 48;
    localparam int BIN_IDX_W   = 16;

    localparam int FLAG_SAT  = 0;
    localparam int FLAG_DROP = 1;

    function automatic logic [REC_W-1:0] pack_record(
        input logic [BIN_IDX_W-1:0] bin_idx,
        input logic [RUN_ID_W-1:0]  run_id,
        input logic [FLAGS_W-1:0]   flags,
        input logic [COUNT_W-1:0]   count
    );
        logic [REC_W-1:0] r;
        r = '0;
        r[BIN_IDX_LSB +: BIN_IDX_W] = bin_idx;
        r[RUN_ID_LSB  +: RUN_ID_W]  = run_id;
        r[FLAGS_LSB   +: FLAGS_W]   = flags;
        r[COUNT_LSB   +: COUNT_W]   = count;
        return r;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous pin followed by a registered
// rising-edge detector. A pin edge shows up on 'rise' three clocks later,
// as a single-cycle pulse.
module sync_edge_det (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic rise
);

    logic sync_p0;
    logic sync_p1;
    logic sync_p2;

    // Synchroniser chain plus registered edge pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
            rise    <= 1'b0;
        end else begin
            sync_p0 <= din;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            rise    <= sync_p1 & ~sync_p2;
        end
    end

endmodule

// File: rtl/photon_bin_sequencer.sv
// Gated photon counter: arm, wait for a trigger, then count photon edges in
// cfg_num_bins consecutive bins of cfg_bin_len clocks, writing one 64-bit
// record per bin into the pulse FIFO. Records are dropped (and counted) when
// the FIFO is full; the sequencer never stalls.
// Optional build macro TRIG_SIM_EN adds a free-running simulated trigger
// selectable with cfg_trig_sel. CNT_W must not exceed 32.
module photon_bin_sequencer
    import photon_seq_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int SIM_PERIOD = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        photon,
    input  logic        tri_in,
    input  logic        arm,
    input  logic        abort,
    input  logic [31:0] cfg_bin_len,
    input  logic [15:0] cfg_num_bins,
    input  logic        cfg_trig_sel,
    input  logic        fifo_full,
    output logic [63:0] writedata,
    output logic        write,
    output logic        busy,
    output logic [15:0] drop_cnt,
    output logic        trig_sim_out
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(
        input logic [CNT_W-1:0] v,
        input logic             inc
    );
        if (inc && (v != CNT_MAX)) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    function automatic logic [15:0] sat_inc_drop(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [COUNT_W-1:0] count_field(input logic [CNT_W-1:0] v);
        logic [COUNT_W-1:0] f;
        f = '0;
        f[CNT_W-1:0] = v;
        return f;
    endfunction

    seq_state_t state_q;
    seq_state_t state_d;

    logic              photon_rise;
    logic              tri_rise;
    logic              trig_hit;

    logic              start_run;
    logic              start_count;
    logic              bin_last;

    logic [31:0]       bin_len_q;
    logic [15:0]       num_bins_q;
    logic [15:0]       bin_idx_q;
    logic [31:0]       clk_in_bin_q;
    logic [CNT_W-1:0]  count_q;
    logic              sat_q;
    logic [CNT_W-1:0]  count_next;
    logic              sat_next;
    logic              drop_pend_q;
    logic [7:0]        run_id_q;
    logic [7:0]        rec_flags;

    sync_edge_det u_photon_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (photon),
        .rise    (photon_rise)
    );

    sync_edge_det u_trig_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (tri_in),
        .rise    (tri_rise)
    );

`ifdef TRIG_SIM_EN
    localparam logic [31:0] SIM_LAST = 32'(SIM_PERIOD - 1);

    logic [31:0] sim_cnt_q;
    logic        trig_sel_q;

    // Free-running period counter; pulses once per SIM_PERIOD clocks
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sim_cnt_q    <= '0;
            trig_sim_out <= 1'b0;
        end else if (sim_cnt_q == SIM_LAST) begin
            sim_cnt_q    <= '0;
            trig_sim_out <= 1'b1;
        end else begin
            sim_cnt_q    <= sim_cnt_q + 32'd1;
            trig_sim_out <= 1'b0;
        end
    end

    // Trigger source is frozen at arm time like the rest of the config
    always_ff @(posedge clk) begin
        if (start_run) begin
            trig_sel_q <= cfg_trig_sel;
        end
    end

    // The simulated pulse is already synchronous, so it bypasses the synchroniser
    assign trig_hit = trig_sel_q ? trig_sim_out : tri_rise;
`else
    logic        unused_trig_sel;
    logic [31:0] unused_sim_period;

    assign unused_trig_sel   = cfg_trig_sel;
    assign unused_sim_period = 32'(SIM_PERIOD);
    assign trig_sim_out      = 1'b0;
    assign trig_hit          = tri_rise;
`endif

    assign busy       = (state_q != IDLE);
    assign count_next = sat_inc_cnt(count_q, photon_rise);
    assign sat_next   = sat_q | (photon_rise & (count_q == CNT_MAX));

    // Flags of the record being closed this cycle
    always_comb begin
        rec_flags            = '0;
        rec_flags[FLAG_SAT]  = sat_next;
        rec_flags[FLAG_DROP] = drop_pend_q;
    end

    // Sequencer state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle control strobes; abort overrides everything
    always_comb begin
        state_d     = state_q;
        start_run   = 1'b0;
        start_count = 1'b0;
        bin_last    = 1'b0;
        case (state_q)
            IDLE: begin
                if (arm && (cfg_num_bins != 16'd0)) begin
                    state_d   = ARMED;
                    start_run = 1'b1;
                end
            end
            ARMED: begin
                if (trig_hit) begin
                    state_d     = COUNT;
                    start_count = 1'b1;
                end
            end
            COUNT: begin
                bin_last = (clk_in_bin_q == (bin_len_q - 32'd1));
                if (bin_last && (bin_idx_q == (num_bins_q - 16'd1))) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (abort) begin
            state_d     = IDLE;
            start_run   = 1'b0;
            start_count = 1'b0;
            bin_last    = 1'b0;
        end
    end

    // Latched run configuration and per-bin accumulators (only meaningful
    // once a run has started, so they carry no reset)
    always_ff @(posedge clk) begin
        if (start_run) begin
            bin_len_q  <= (cfg_bin_len == 32'd0) ? 32'd1 : cfg_bin_len;
            num_bins_q <= cfg_num_bins;
        end
        if (start_count) begin
            bin_idx_q    <= '0;
            clk_in_bin_q <= '0;
            count_q      <= '0;
            sat_q        <= 1'b0;
        end else if (state_q == COUNT) begin
            if (bin_last) begin
                bin_idx_q    <= bin_idx_q + 16'd1;
                clk_in_bin_q <= '0;
                count_q      <= '0;
                sat_q        <= 1'b0;
            end else begin
                clk_in_bin_q <= clk_in_bin_q + 32'd1;
                count_q      <= count_next;
                sat_q        <= sat_next;
            end
        end
    end

    // Record emission, drop accounting and run numbering
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            writedata   <= '0;
            write       <= 1'b0;
            drop_cnt    <= '0;
            drop_pend_q <= 1'b0;
            run_id_q    <= '0;
        end else begin
            write <= 1'b0;
            if (start_run) begin
                run_id_q <= run_id_q + 8'd1;
            end
            if (bin_last) begin
                if (!fifo_full) begin
                    write       <= 1'b1;
                    writedata   <= pack_record(bin_idx_q, run_id_q, rec_flags,
                                               count_field(count_next));
                    drop_pend_q <= 1'b0;
                end else begin
                    drop_cnt    <= sat_inc_drop(drop_cnt);
                    drop_pend_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_photon_bin_sequencer.sv
// Directed bench for photon_bin_sequencer: reset state, bin counting, bin
// boundary ownership, FIFO-full drops, abort, ignored arms, bin_len=0 and
// (with TRIG_SIM_EN) the simulated trigger.
module tb_photon_bin_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        photon;
    logic        tri_in;
    logic        arm;
    logic        abort;
    logic [31:0] cfg_bin_len;
    logic [15:0] cfg_num_bins;
    logic        cfg_trig_sel;
    logic        fifo_full;
    logic [63:0] writedata;
    logic        write;
    logic        busy;
    logic [15:0] drop_cnt;
    logic        trig_sim_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int c0    = 0;

    typedef struct {
        logic [63:0] data;
        int          t;
        logic        b;
    } wr_t;

    wr_t  wr_q[$];
    logic busy_log[64];

    photon_bin_sequencer #(
        .CNT_W      (32),
        .SIM_PERIOD (100)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .photon       (photon),
        .tri_in       (tri_in),
        .arm          (arm),
        .abort        (abort),
        .cfg_bin_len  (cfg_bin_len),
        .cfg_num_bins (cfg_num_bins),
        .cfg_trig_sel (cfg_trig_sel),
        .fifo_full    (fifo_full),
        .writedata    (writedata),
        .write        (write),
        .busy         (busy),
        .drop_cnt     (drop_cnt),
        .trig_sim_out (trig_sim_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every write strobe with its cycle stamp and busy level
    always @(negedge clk) begin
        if (write === 1'b1) begin
            wr_q.push_back('{writedata, cyc, busy});
        end
    end

    function automatic logic [63:0] rec(input int b, input int rid, input int fl, input int cnt);
        return {b[15:0], rid[7:0], fl[7:0], cnt[31:0]};
    endfunction

    task automatic do_arm(input int len, input int nb, input logic sel);
        @(negedge clk);
        cfg_bin_len  = 32'(len);
        cfg_num_bins = 16'(nb);
        cfg_trig_sel = sel;
        arm          = 1'b1;
        @(negedge clk);
        arm          = 1'b0;
        // later cfg changes must not affect the armed run
        cfg_bin_len  = 32'd7;
        cfg_num_bins = 16'd5;
    endtask

    // Negedge j drives tri_in (j==0), photon=ph[j], fifo_full=fm[j], abort at j==abort_at
    task automatic drive_run(input logic [63:0] ph, input logic [63:0] fm,
                             input int abort_at, input int nj);
        @(negedge clk);
        wr_q.delete();
        c0 = cyc;
        for (int j = 0; j < nj; j++) begin
            busy_log[j] = busy;
            tri_in      = (j == 0);
            photon      = ph[j];
            fifo_full   = fm[j];
            abort       = (j == abort_at);
            @(negedge clk);
        end
        tri_in    = 1'b0;
        photon    = 1'b0;
        fifo_full = 1'b0;
        abort     = 1'b0;
    endtask

    task automatic test_reset();
        reset_n      = 1'b0;
        photon       = 1'b0;
        tri_in       = 1'b0;
        arm          = 1'b0;
        abort        = 1'b0;
        cfg_bin_len  = 32'd0;
        cfg_num_bins = 16'd0;
        cfg_trig_sel = 1'b0;
        fifo_full    = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (writedata !== 64'd0) begin bad++; $display("FAIL reset_writedata got=%h want=0", writedata); end
        total++; if (write !== 1'b0) begin bad++; $display("FAIL reset_write got=%b want=0", write); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (drop_cnt !== 16'd0) begin bad++; $display("FAIL reset_drop_cnt got=%0d want=0", drop_cnt); end
        total++; if (trig_sim_out !== 1'b0) begin bad++; $display("FAIL reset_trig_sim got=%b want=0", trig_sim_out); end
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [63:0] ph;
        ph = '0;
        for (int b = 0; b < 3; b++) begin
            for (int k = 1; k < 8; k += 2) ph[b*10 + k + 1] = 1'b1;
        end
        do_arm(10, 3, 1'b0);
        drive_run(ph, 64'd0, -1, 42);
        total++; if (wr_q.size() != 3) begin bad++; $display("FAIL basic_nwrites got=%0d want=3", wr_q.size()); end
        for (int b = 0; b < 3; b++) begin
            if (b < wr_q.size()) begin
                total++; if (wr_q[b].data !== rec(b, 1, 0, 4)) begin bad++; $display("FAIL basic_rec[%0d] got=%h want=%h", b, wr_q[b].data, rec(b, 1, 0, 4)); end
                total++; if (wr_q[b].t != c0 + 4 + (b+1)*10) begin bad++; $display("FAIL basic_time[%0d] got=%0d want=%0d", b, wr_q[b].t - c0, 4 + (b+1)*10); end
                total++; if (wr_q[b].b !== (b != 2)) begin bad++; $display("FAIL basic_busy_at_write[%0d] got=%b want=%b", b, wr_q[b].b, b != 2); end
            end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b want=0", busy); end
    endtask

    task automatic test_boundary();
        logic [63:0] ph;
        int          exp_a[3];
        int          exp_b[3];
        exp_a = '{1, 0, 1};
        exp_b = '{0, 1, 0};
        // edges on last clk of bin 0 and first clk of bin 2
        ph = '0; ph[10] = 1'b1; ph[21] = 1'b1;
        do_arm(10, 3, 1'b0);
        drive_run(ph, 64'd0, -1, 40);
        total++; if (wr_q.size() != 3) begin bad++; $display("FAIL bound_a_nwrites got=%0d want=3", wr_q.size()); end
        for (int b = 0; b < 3; b++) begin
            if (b < wr_q.size()) begin
                total++; if (wr_q[b].data !== rec(b, 2, 0, exp_a[b])) begin bad++; $display("FAIL bound_a_rec[%0d] got=%h want=%h", b, wr_q[b].data, rec(b, 2, 0, exp_a[b])); end
            end
        end
        // edge on first clk of bin 1
        ph = '0; ph[11] = 1'b1;
        do_arm(10, 3, 1'b0);
        drive_run(ph, 64'd0, -1, 40);
        total++; if (wr_q.size() != 3) begin bad++; $display("FAIL bound_b_nwrites got=%0d want=3", wr_q.size()); end
        for (int b = 0; b < 3; b++) begin
            if (b < wr_q.size()) begin
                total++; if (wr_q[b].data !== rec(b, 3, 0, exp_b[b])) begin bad++; $display("FAIL bound_b_rec[%0d] got=%h want=%h", b, wr_q[b].data, rec(b, 3, 0, exp_b[b])); end
            end
        end
    endtask

    task automatic test_fifo_full();
        logic [63:0] fm;
        fm = '0;
        for (int j = 14; j <= 24; j++) fm[j] = 1'b1;
        do_arm(10, 3, 1'b0);
        drive_run(64'd0, fm, -1, 40);
        total++; if (wr_q.size() != 2) begin bad++; $display("FAIL full_nwrites got=%0d want=2", wr_q.size()); end
        if (wr_q.size() >= 2) begin
            total++; if (wr_q[0].data !== rec(0, 4, 0, 0)) begin bad++; $display("FAIL full_rec0 got=%h want=%h", wr_q[0].data, rec(0, 4, 0, 0)); end
            total++; if (wr_q[1].data !== rec(2, 4, 2, 0)) begin bad++; $display("FAIL full_rec2 got=%h want=%h", wr_q[1].data, rec(2, 4, 2, 0)); end
            total++; if (wr_q[1].t != c0 + 34) begin bad++; $display("FAIL full_time2 got=%0d want=34", wr_q[1].t - c0); end
        end
        total++; if (drop_cnt !== 16'd1) begin bad++; $display("FAIL full_drop_cnt got=%0d want=1", drop_cnt); end
    endtask

    task automatic test_abort();
        do_arm(10, 3, 1'b0);
        drive_run(64'd0, 64'd0, 15, 40);
        total++; if (wr_q.size() != 1) begin bad++; $display("FAIL abort_nwrites got=%0d want=1", wr_q.size()); end
        if (wr_q.size() >= 1) begin
            total++; if (wr_q[0].data !== rec(0, 5, 0, 0)) begin bad++; $display("FAIL abort_rec0 got=%h want=%h", wr_q[0].data, rec(0, 5, 0, 0)); end
        end
        total++; if (busy_log[15] !== 1'b1) begin bad++; $display("FAIL abort_busy_before got=%b want=1", busy_log[15]); end
        total++; if (busy_log[16] !== 1'b0) begin bad++; $display("FAIL abort_busy_after got=%b want=0", busy_log[16]); end
        do_arm(5, 1, 1'b0);
        drive_run(64'd0, 64'd0, -1, 20);
        total++; if (wr_q.size() != 1) begin bad++; $display("FAIL rearm_nwrites got=%0d want=1", wr_q.size()); end
        if (wr_q.size() >= 1) begin
            total++; if (wr_q[0].data !== rec(0, 6, 0, 0)) begin bad++; $display("FAIL rearm_rec got=%h want=%h", wr_q[0].data, rec(0, 6, 0, 0)); end
            total++; if (wr_q[0].t != c0 + 9) begin bad++; $display("FAIL rearm_time got=%0d want=9", wr_q[0].t - c0); end
        end
    endtask

    task automatic test_zero_cfg();
        do_arm(10, 0, 1'b0);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL zero_bins_busy got=%b want=0", busy); end
        @(negedge clk);
        cfg_num_bins = 16'd2;
        arm          = 1'b1;
        abort        = 1'b1;
        @(negedge clk);
        arm          = 1'b0;
        abort        = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_over_arm_busy got=%b want=0", busy); end
        do_arm(0, 3, 1'b0);
        drive_run(64'd0, 64'd0, -1, 14);
        total++; if (wr_q.size() != 3) begin bad++; $display("FAIL len0_nwrites got=%0d want=3", wr_q.size()); end
        for (int b = 0; b < 3; b++) begin
            if (b < wr_q.size()) begin
                total++; if (wr_q[b].data !== rec(b, 7, 0, 0)) begin bad++; $display("FAIL len0_rec[%0d] got=%h want=%h", b, wr_q[b].data, rec(b, 7, 0, 0)); end
                total++; if (wr_q[b].t != c0 + 5 + b) begin bad++; $display("FAIL len0_time[%0d] got=%0d want=%0d", b, wr_q[b].t - c0, 5 + b); end
            end
        end
    endtask

`ifdef TRIG_SIM_EN
    task automatic test_sim_trigger();
        int  t1;
        int  t2;
        int  t3;
        logic got;
        t1 = -1; t2 = -1; t3 = -1;
        for (int i = 0; i < 300 && t2 < 0; i++) begin
            @(negedge clk);
            if (trig_sim_out === 1'b1) begin
                if (t1 < 0) t1 = cyc; else t2 = cyc;
            end
        end
        total++; if (t2 - t1 != 100) begin bad++; $display("FAIL sim_period got=%0d want=100", t2 - t1); end
        do_arm(5, 1, 1'b1);
        wr_q.delete();
        for (int i = 0; i < 300 && t3 < 0; i++) begin
            @(negedge clk);
            if (trig_sim_out === 1'b1) t3 = cyc;
        end
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (wr_q.size() > 0) got = 1'b1;
        end
        total++; if (!got) begin bad++; $display("FAIL sim_run_write got=none want=1"); end
        if (got) begin
            total++; if (wr_q[0].data !== rec(0, 8, 0, 0)) begin bad++; $display("FAIL sim_rec got=%h want=%h", wr_q[0].data, rec(0, 8, 0, 0)); end
            total++; if (wr_q[0].t != t3 + 6) begin bad++; $display("FAIL sim_time got=%0d want=%0d", wr_q[0].t, t3 + 6); end
        end
    endtask
`else
    task automatic test_sim_trigger();
        for (int i = 0; i < 4; i++) begin
            repeat (37) @(negedge clk);
            total++; if (trig_sim_out !== 1'b0) begin bad++; $display("FAIL sim_tied_low got=%b want=0", trig_sim_out); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_boundary();
        test_fifo_full();
        test_abort();
        test_zero_cfg();
        test_sim_trigger();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
